// File: rtl/boot_cmd_engine.sv
`timescale 1ns/1ps
// boot_cmd_engine
// UART bootloader protocol engine. Assembles received bytes into 32-bit
// little-endian words and decodes command headers. A write command streams
// payload words into IMEM. A read command streams DMEM words back out as
// transmit bytes. boot_busy keeps the CPU core in reset while a command runs.
//
// Header word: bit31 = 1 write-IMEM / 0 read-DMEM, [30:16] word address,
// [15:0] word count (0 = no-op).
//
// Optional feature (macro BOOT_RX_TIMEOUT_EN): an inter-byte gap timeout in a
// partial header or in a write payload aborts to the header state and pulses
// cmd_err. Without the macro, cmd_err is tied low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_data, rx_valid        received byte, one-cycle strobe
//   tx_data, tx_valid        byte to transmit, held until tx_ready
//   tx_ready                 transmitter accepts when tx_valid && tx_ready
//   imem_we/addr/wdata       IMEM write port (one-cycle strobe)
//   dmem_re/addr, dmem_rdata DMEM read port (data one cycle after dmem_re)
//   boot_busy                high whenever a command is in progress
//   cmd_err                  one-cycle pulse on timeout abort
module boot_cmd_engine #(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dmem_re,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_rdata,
  output logic              boot_busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    HDR,
    WR_DATA,
    RD_REQ,
    RD_WAIT,
    RD_SEND
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [1:0]        bcnt;
  logic [23:0]       rx_word;
  logic [31:0]       full_word;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  count;
  logic [31:0]       tx_sh;
  logic              rx_phase;
  logic              word_done;
  logic              last_word;
  logic              timeout;

  // Only the first three bytes are stored; the fourth is merged on the fly.
  assign full_word = {rx_data, rx_word};
  assign rx_phase  = (state == HDR) || (state == WR_DATA);
  assign word_done = rx_phase && rx_valid && (bcnt == 2'd3);
  assign last_word = (count == LEN_W'(1));

`ifdef BOOT_RX_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap;
  logic             gap_active;

  assign gap_active = ((state == HDR) && (bcnt != 2'd0)) || (state == WR_DATA);
  assign timeout    = gap_active && !rx_valid && (gap == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap     <= '0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= timeout;
      if (!gap_active || rx_valid || timeout) begin
        gap <= '0;
      end else begin
        gap <= gap + GAP_W'(1);
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign cmd_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HDR;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = HDR;
    end else begin
      unique case (state)
        HDR: begin
          if (word_done && (full_word[LEN_W-1:0] != '0)) begin
            state_nx = full_word[31] ? WR_DATA : RD_REQ;
          end
        end
        WR_DATA: begin
          if (word_done && last_word) begin
            state_nx = HDR;
          end
        end
        RD_REQ:  state_nx = RD_WAIT;
        RD_WAIT: state_nx = RD_SEND;
        RD_SEND: begin
          if (tx_ready && (bcnt == 2'd3)) begin
            state_nx = last_word ? HDR : RD_REQ;
          end
        end
        default: state_nx = HDR;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    boot_busy = (state != HDR);
    dmem_re   = (state == RD_REQ);
    tx_valid  = (state == RD_SEND);
    tx_data   = (state == RD_SEND) ? tx_sh[7:0] : '0;
  end

  assign dmem_addr = addr;

  // Datapath: byte assembly, header latch, IMEM write register, TX shifter.
  // The byte counter is shared between RX assembly and TX byte sequencing;
  // RX bytes are ignored outside HDR/WR_DATA so the two never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt       <= '0;
      rx_word    <= '0;
      addr       <= '0;
      count      <= '0;
      tx_sh      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (timeout) begin
        bcnt    <= '0;
        rx_word <= '0;
      end else begin
        unique case (state)
          HDR, WR_DATA: begin
            if (rx_valid) begin
              bcnt <= bcnt + 2'd1;
              unique case (bcnt)
                2'd0:    rx_word[7:0]   <= rx_data;
                2'd1:    rx_word[15:8]  <= rx_data;
                2'd2:    rx_word[23:16] <= rx_data;
                default: rx_word        <= '0;
              endcase
              if (bcnt == 2'd3) begin
                if (state == HDR) begin
                  addr  <= full_word[16 +: ADDR_W];
                  count <= full_word[LEN_W-1:0];
                end else begin
                  imem_we    <= 1'b1;
                  imem_addr  <= addr;
                  imem_wdata <= full_word;
                  addr       <= addr + ADDR_W'(1);
                  count      <= count - LEN_W'(1);
                end
              end
            end
          end
          RD_WAIT: tx_sh <= dmem_rdata;
          RD_SEND: begin
            if (tx_ready) begin
              tx_sh <= {8'h00, tx_sh[31:8]};
              bcnt  <= bcnt + 2'd1;
              if (bcnt == 2'd3) begin
                addr  <= addr + ADDR_W'(1);
                count <= count - LEN_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
